// File: rtl/axis_coincidence_pkg.sv
// Shared definitions for the coincidence reader: FSM state encoding,
// status-counter width and a constant-evaluable ceil(log2) helper.
package axis_coincidence_pkg;

   localparam int STS_WIDTH = 32;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WINDOW  = 3'd1,
      ST_REDUCE  = 3'd2,
      ST_SUM     = 3'd3,
      ST_DECIDE  = 3'd4,
      ST_SEND    = 3'd5,
      ST_HOLDOFF = 3'd6
   } state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/axis_coincidence_mult.sv
// Group multiplicity pipeline: registered per-group OR of the hit mask,
// then a registered popcount of the group flags.
module axis_coincidence_mult
   import axis_coincidence_pkg::*;
#(
   parameter int DET_WIDTH   = 64,
   parameter int GROUP_WIDTH = 16,
   localparam int NGROUPS    = DET_WIDTH / GROUP_WIDTH,
   localparam int SUM_WIDTH  = clog2(NGROUPS + 1)
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 reduce_en,
   input  logic [DET_WIDTH-1:0] mask,
   input  logic                 sum_en,
   output logic [SUM_WIDTH-1:0] sum
);

   logic [NGROUPS-1:0]   grp;
   logic [NGROUPS-1:0]   grp_next;
   logic [SUM_WIDTH-1:0] sum_next;

   always_comb begin
      grp_next = '0;
      for (int g = 0; g < NGROUPS; g++) begin
         grp_next[g] = |mask[g*GROUP_WIDTH +: GROUP_WIDTH];
      end
   end

   // SUM_WIDTH holds NGROUPS exactly, so the running total cannot wrap.
   always_comb begin
      sum_next = '0;
      for (int g = 0; g < NGROUPS; g++) begin
         sum_next = sum_next + SUM_WIDTH'(grp[g]);
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         grp <= '0;
         sum <= '0;
      end else begin
         if (reduce_en) begin
            grp <= grp_next;
         end
         if (sum_en) begin
            sum <= sum_next;
         end
      end
   end

endmodule

// File: rtl/axis_coincidence_reader.sv
// Detector coincidence reader: synchronises hit lines, accumulates a hit
// window, checks group multiplicity and emits {timestamp, mask} on AXI4-Stream.
module axis_coincidence_reader
   import axis_coincidence_pkg::*;
#(
   parameter int DET_WIDTH   = 64,
   parameter int GROUP_WIDTH = 16,
   parameter int TIME_WIDTH  = 64,
   parameter int CNTR_WIDTH  = 8,
   localparam int NGROUPS    = DET_WIDTH / GROUP_WIDTH,
   localparam int SUM_WIDTH  = clog2(NGROUPS + 1)
) (
   input  logic                            aclk,
   input  logic                            aresetn,
   input  logic [DET_WIDTH-1:0]            det_data,
   input  logic [CNTR_WIDTH-1:0]           cfg_window,
   input  logic [SUM_WIDTH-1:0]            cfg_mult,
   input  logic [CNTR_WIDTH-1:0]           cfg_holdoff,
   output logic [TIME_WIDTH+DET_WIDTH-1:0] m_axis_tdata,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [STS_WIDTH-1:0]            sts_accepted,
   output logic [STS_WIDTH-1:0]            sts_lost
);

   logic [DET_WIDTH-1:0]  cdc_sync [4];
   logic [DET_WIDTH-1:0]  s;
   logic [DET_WIDTH-1:0]  s_prev;
   logic [TIME_WIDTH-1:0] time_cnt;

   state_t                state;
   state_t                state_next;
   logic [CNTR_WIDTH-1:0] cntr;
   logic [CNTR_WIDTH-1:0] cntr_next;
   logic [DET_WIDTH-1:0]  mask;
   logic [DET_WIDTH-1:0]  mask_next;
   logic [TIME_WIDTH-1:0] ts;
   logic [TIME_WIDTH-1:0] ts_next;
   logic [CNTR_WIDTH-1:0] win_len;
   logic [CNTR_WIDTH-1:0] win_len_next;
   logic [SUM_WIDTH-1:0]  mult_min;
   logic [SUM_WIDTH-1:0]  mult_min_next;
   logic [CNTR_WIDTH-1:0] hold_len;
   logic [CNTR_WIDTH-1:0] hold_len_next;
   logic                  tvalid;
   logic                  tvalid_next;

   logic                  reduce_en;
   logic                  sum_en;
   logic [SUM_WIDTH-1:0]  sum;
   logic                  accept;
   logic                  onset;
   logic                  lose;

   // Four-stage synchroniser equivalent to xpm_cdc_array_single; left unreset
   // so the hit lines never see a reset-to-data path.
   always_ff @(posedge aclk) begin
      cdc_sync[0] <= det_data;
      for (int i = 1; i < 4; i++) begin
         cdc_sync[i] <= cdc_sync[i-1];
      end
   end

   assign s = cdc_sync[3];

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         s_prev   <= '0;
         time_cnt <= '0;
      end else begin
         s_prev   <= s;
         time_cnt <= time_cnt + TIME_WIDTH'(1);
      end
   end

   axis_coincidence_mult #(
      .DET_WIDTH   (DET_WIDTH),
      .GROUP_WIDTH (GROUP_WIDTH)
   ) u_mult (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .reduce_en (reduce_en),
      .mask      (mask),
      .sum_en    (sum_en),
      .sum       (sum)
   );

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state    <= ST_IDLE;
         cntr     <= '0;
         mask     <= '0;
         ts       <= '0;
         win_len  <= '0;
         mult_min <= '0;
         hold_len <= '0;
         tvalid   <= 1'b0;
      end else begin
         state    <= state_next;
         cntr     <= cntr_next;
         mask     <= mask_next;
         ts       <= ts_next;
         win_len  <= win_len_next;
         mult_min <= mult_min_next;
         hold_len <= hold_len_next;
         tvalid   <= tvalid_next;
      end
   end

   // Config is sampled only on the IDLE->WINDOW transition so the event in
   // flight is immune to later cfg_* changes.
   always_comb begin
      state_next    = state;
      cntr_next     = cntr;
      mask_next     = mask;
      ts_next       = ts;
      win_len_next  = win_len;
      mult_min_next = mult_min;
      hold_len_next = hold_len;
      tvalid_next   = tvalid;
      reduce_en     = 1'b0;
      sum_en        = 1'b0;
      accept        = 1'b0;

      case (state)
         ST_IDLE: begin
            mask_next = s;
            cntr_next = '0;
            if (|s) begin
               ts_next       = time_cnt;
               win_len_next  = cfg_window;
               mult_min_next = cfg_mult;
               hold_len_next = cfg_holdoff;
               state_next    = ST_WINDOW;
            end
         end
         ST_WINDOW: begin
            mask_next = mask | s;
            cntr_next = cntr + CNTR_WIDTH'(1);
            if (cntr >= win_len) begin
               state_next = ST_REDUCE;
            end
         end
         ST_REDUCE: begin
            reduce_en  = 1'b1;
            state_next = ST_SUM;
         end
         ST_SUM: begin
            sum_en     = 1'b1;
            state_next = ST_DECIDE;
         end
         ST_DECIDE: begin
            if (sum >= mult_min) begin
               tvalid_next = 1'b1;
               state_next  = ST_SEND;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (tvalid && m_axis_tready) begin
               tvalid_next = 1'b0;
               accept      = 1'b1;
               if (hold_len != '0) begin
                  cntr_next  = CNTR_WIDTH'(1);
                  state_next = ST_HOLDOFF;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         ST_HOLDOFF: begin
            cntr_next = cntr + CNTR_WIDTH'(1);
            if (cntr >= hold_len) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign onset = (|s) & ~(|s_prev);
   assign lose  = onset && ((state == ST_SEND) || (state == ST_HOLDOFF));

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         sts_accepted <= '0;
         sts_lost     <= '0;
      end else begin
         if (accept && (sts_accepted != '1)) begin
            sts_accepted <= sts_accepted + STS_WIDTH'(1);
         end
         if (lose && (sts_lost != '1)) begin
            sts_lost <= sts_lost + STS_WIDTH'(1);
         end
      end
   end

   assign m_axis_tdata  = {ts, mask};
   assign m_axis_tvalid = tvalid;

endmodule

// File: tb/tb_axis_coincidence_reader.sv
// Directed bench for axis_coincidence_reader: a 64/16 instance for the main
// scenarios and a 32/8 instance for the narrow-configuration multiplicity cases.
module tb_axis_coincidence_reader;

   logic         aclk = 1'b0;
   logic         aresetn;
   logic [63:0]  det_data;
   logic [7:0]   cfg_window;
   logic [2:0]   cfg_mult;
   logic [7:0]   cfg_holdoff;
   logic [127:0] m_axis_tdata;
   logic         m_axis_tvalid;
   logic         m_axis_tready;
   logic [31:0]  sts_accepted;
   logic [31:0]  sts_lost;

   logic [31:0]  det32;
   logic [7:0]   cfg_window32;
   logic [2:0]   cfg_mult32;
   logic [7:0]   cfg_holdoff32;
   logic [95:0]  tdata32;
   logic         tvalid32;
   logic         tready32;
   logic [31:0]  accepted32;
   logic [31:0]  lost32;

   int cyc;
   int tests_run;
   int tests_failed;
   int exp_acc;
   int exp_lost;

   always #5 aclk = ~aclk;

   // Cycles since reset release; equals the DUT timestamp for the current cycle.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   axis_coincidence_reader #(
      .DET_WIDTH(64), .GROUP_WIDTH(16), .TIME_WIDTH(64), .CNTR_WIDTH(8)
   ) dut (
      .aclk(aclk), .aresetn(aresetn), .det_data(det_data),
      .cfg_window(cfg_window), .cfg_mult(cfg_mult), .cfg_holdoff(cfg_holdoff),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .sts_accepted(sts_accepted), .sts_lost(sts_lost)
   );

   axis_coincidence_reader #(
      .DET_WIDTH(32), .GROUP_WIDTH(8), .TIME_WIDTH(64), .CNTR_WIDTH(8)
   ) dut32 (
      .aclk(aclk), .aresetn(aresetn), .det_data(det32),
      .cfg_window(cfg_window32), .cfg_mult(cfg_mult32), .cfg_holdoff(cfg_holdoff32),
      .m_axis_tdata(tdata32), .m_axis_tvalid(tvalid32),
      .m_axis_tready(tready32),
      .sts_accepted(accepted32), .sts_lost(lost32)
   );

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic pulse(input logic [63:0] bits);
      det_data = bits;
      step(1);
      det_data = '0;
   endtask

   task automatic pulse32(input logic [31:0] bits);
      det32 = bits;
      step(1);
      det32 = '0;
   endtask

   task automatic wait_valid(input int budget, output int at_cyc);
      at_cyc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge aclk);
         if (m_axis_tvalid) begin
            at_cyc = cyc;
            break;
         end
      end
   endtask

   task automatic wait_valid32(input int budget, output int at_cyc);
      at_cyc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge aclk);
         if (tvalid32) begin
            at_cyc = cyc;
            break;
         end
      end
   endtask

   task automatic check_counters(input string name);
      tests_run++;
      if (sts_accepted !== 32'(exp_acc) || sts_lost !== 32'(exp_lost)) begin
         tests_failed++;
         $display("[TB] FAIL %s: accepted=%0d lost=%0d, expected accepted=%0d lost=%0d",
                  name, sts_accepted, sts_lost, exp_acc, exp_lost);
      end
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      det_data = '0; det32 = '0;
      cfg_window = 8'd4; cfg_mult = 3'd1; cfg_holdoff = 8'd0; m_axis_tready = 1'b1;
      cfg_window32 = 8'd4; cfg_mult32 = 3'd4; cfg_holdoff32 = 8'd0; tready32 = 1'b1;
      exp_acc = 0; exp_lost = 0;
      step(6);
      tests_run++;
      if (m_axis_tvalid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_tvalid: got %b, expected 0", m_axis_tvalid);
      end
      tests_run++;
      if (m_axis_tdata !== 128'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_tdata: got %h, expected 0", m_axis_tdata);
      end
      check_counters("reset_counters");
      aresetn = 1'b1;
   endtask

   task automatic test_single_hit();
      int at;
      cfg_window = 8'd4; cfg_mult = 3'd1; cfg_holdoff = 8'd0; m_axis_tready = 1'b1;
      while (cyc < 96) step(1);
      pulse(64'h8);
      wait_valid(40, at);
      tests_run++;
      if (at != 109) begin
         tests_failed++;
         $display("[TB] FAIL single_hit_cycle: got %0d, expected 109", at);
      end
      tests_run++;
      if (m_axis_tdata !== {64'd100, 64'h8}) begin
         tests_failed++;
         $display("[TB] FAIL single_hit_tdata: got %h, expected %h", m_axis_tdata, {64'd100, 64'h8});
      end
      step(1);
      exp_acc++;
      tests_run++;
      if (m_axis_tvalid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL single_hit_drop: tvalid=%b after handshake, expected 0", m_axis_tvalid);
      end
      check_counters("single_hit_counters");
      step(10);
   endtask

   task automatic test_multiplicity();
      int at;
      int k;
      logic [127:0] expd;
      cfg_window = 8'd8; cfg_mult = 3'd2; cfg_holdoff = 8'd0; m_axis_tready = 1'b1;
      k = cyc;
      pulse(64'h1);
      step(2);
      pulse(64'h100000);
      wait_valid(40, at);
      expd = {64'(k + 4), 64'h100001};
      tests_run++;
      if (at != k + 17) begin
         tests_failed++;
         $display("[TB] FAIL mult2_cycle: got %0d, expected %0d", at, k + 17);
      end
      tests_run++;
      if (m_axis_tdata !== expd) begin
         tests_failed++;
         $display("[TB] FAIL mult2_tdata: got %h, expected %h", m_axis_tdata, expd);
      end
      step(1);
      exp_acc++;
      check_counters("mult2_counters");
      step(10);

      cfg_mult = 3'd3;
      pulse(64'h1);
      step(2);
      pulse(64'h100000);
      wait_valid(40, at);
      tests_run++;
      if (at != -1) begin
         tests_failed++;
         $display("[TB] FAIL mult3_reject: beat at cycle %0d, expected none", at);
      end
      check_counters("mult3_counters");
      step(10);
   endtask

   task automatic test_backpressure();
      int at;
      int k;
      logic [127:0] expd;
      cfg_window = 8'd4; cfg_mult = 3'd1; cfg_holdoff = 8'd0; m_axis_tready = 1'b0;
      k = cyc;
      pulse(64'h0000_0100_0000_0000);
      wait_valid(40, at);
      expd = {64'(k + 4), 64'h0000_0100_0000_0000};
      tests_run++;
      if (at != k + 13) begin
         tests_failed++;
         $display("[TB] FAIL stall_cycle: got %0d, expected %0d", at, k + 13);
      end
      for (int i = 0; i < 50; i++) begin
         @(posedge aclk); #1;
         det_data = (i == 5 || i == 15 || i == 25) ? 64'h1 : 64'h0;
         @(negedge aclk);
         tests_run++;
         if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== expd) begin
            tests_failed++;
            $display("[TB] FAIL stall_hold[%0d]: tvalid=%b tdata=%h, expected 1 / %h",
                     i, m_axis_tvalid, m_axis_tdata, expd);
         end
      end
      m_axis_tready = 1'b1;
      step(1);
      exp_acc++;
      exp_lost += 3;
      tests_run++;
      if (m_axis_tvalid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL stall_release: tvalid=%b, expected 0", m_axis_tvalid);
      end
      check_counters("stall_counters");
      step(10);
   endtask

   task automatic test_holdoff();
      int beats[$];
      int k;
      logic [127:0] first_data;
      cfg_window = 8'd4; cfg_mult = 3'd1; cfg_holdoff = 8'd10; m_axis_tready = 1'b1;
      k = 0;
      first_data = '0;
      for (int i = 0; i < 70; i++) begin
         @(posedge aclk); #1;
         if (i == 0) k = cyc;
         det_data = (i % 2 == 0 && i < 60) ? 64'h2 : 64'h0;
         @(negedge aclk);
         if (m_axis_tvalid) begin
            if (beats.size() == 0) first_data = m_axis_tdata;
            beats.push_back(cyc);
         end
      end
      det_data = '0;
      step(20);
      tests_run++;
      if (beats.size() != 3) begin
         tests_failed++;
         $display("[TB] FAIL holdoff_beats: got %0d beats, expected 3", beats.size());
      end
      if (beats.size() >= 3) begin
         tests_run++;
         if (beats[0] != k + 13 || beats[1] - beats[0] != 20 || beats[2] - beats[1] != 20) begin
            tests_failed++;
            $display("[TB] FAIL holdoff_spacing: beats at %0d %0d %0d, expected %0d %0d %0d",
                     beats[0], beats[1], beats[2], k + 13, k + 33, k + 53);
         end
      end
      tests_run++;
      if (first_data !== {64'(k + 4), 64'h2}) begin
         tests_failed++;
         $display("[TB] FAIL holdoff_tdata: got %h, expected %h", first_data, {64'(k + 4), 64'h2});
      end
      exp_acc += 3;
      exp_lost += 15;
      check_counters("holdoff_counters");
   endtask

   task automatic test_reset_mid_event();
      int at;
      int k;
      cfg_window = 8'd8; cfg_mult = 3'd1; cfg_holdoff = 8'd0; m_axis_tready = 1'b1;
      pulse(64'h10);
      step(8);
      aresetn = 1'b0;
      #1;
      exp_acc = 0; exp_lost = 0;
      tests_run++;
      if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 128'd0) begin
         tests_failed++;
         $display("[TB] FAIL rst_window_out: tvalid=%b tdata=%h, expected 0 / 0", m_axis_tvalid, m_axis_tdata);
      end
      check_counters("rst_window_counters");
      step(3);
      aresetn = 1'b1;
      k = cyc;
      pulse(64'h20);
      wait_valid(40, at);
      tests_run++;
      if (at != k + 17 || m_axis_tdata !== {64'(k + 4), 64'h20}) begin
         tests_failed++;
         $display("[TB] FAIL rst_window_next: cycle %0d tdata %h, expected %0d / %h",
                  at, m_axis_tdata, k + 17, {64'(k + 4), 64'h20});
      end
      step(1);
      exp_acc++;
      check_counters("rst_window_after");
      step(10);

      m_axis_tready = 1'b0;
      k = cyc;
      pulse(64'h40);
      wait_valid(40, at);
      tests_run++;
      if (at != k + 17) begin
         tests_failed++;
         $display("[TB] FAIL rst_send_reach: got cycle %0d, expected %0d", at, k + 17);
      end
      aresetn = 1'b0;
      #1;
      exp_acc = 0; exp_lost = 0;
      tests_run++;
      if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 128'd0) begin
         tests_failed++;
         $display("[TB] FAIL rst_send_out: tvalid=%b tdata=%h, expected 0 / 0", m_axis_tvalid, m_axis_tdata);
      end
      check_counters("rst_send_counters");
      step(3);
      aresetn = 1'b1;
      m_axis_tready = 1'b1;
      k = cyc;
      pulse(64'h80);
      wait_valid(40, at);
      tests_run++;
      if (at != k + 17 || m_axis_tdata !== {64'(k + 4), 64'h80}) begin
         tests_failed++;
         $display("[TB] FAIL rst_send_next: cycle %0d tdata %h, expected %0d / %h",
                  at, m_axis_tdata, k + 17, {64'(k + 4), 64'h80});
      end
      step(1);
      exp_acc++;
      check_counters("rst_send_after");
      step(10);
   endtask

   task automatic test_width32();
      int at;
      int k;
      logic [95:0] expd;
      cfg_window32 = 8'd4; cfg_mult32 = 3'd4; cfg_holdoff32 = 8'd0; tready32 = 1'b1;
      k = cyc;
      pulse32(32'h8040_2010);
      wait_valid32(40, at);
      expd = {64'(k + 4), 32'h8040_2010};
      tests_run++;
      if (at != k + 13 || tdata32 !== expd) begin
         tests_failed++;
         $display("[TB] FAIL w32_m4: cycle %0d tdata %h, expected %0d / %h", at, tdata32, k + 13, expd);
      end
      step(1);
      tests_run++;
      if (accepted32 !== 32'd1) begin
         tests_failed++;
         $display("[TB] FAIL w32_m4_count: got %0d, expected 1", accepted32);
      end
      step(10);

      cfg_mult32 = 3'd5;
      pulse32(32'h8040_2010);
      wait_valid32(40, at);
      tests_run++;
      if (at != -1 || accepted32 !== 32'd1) begin
         tests_failed++;
         $display("[TB] FAIL w32_m5: beat cycle %0d accepted %0d, expected none / 1", at, accepted32);
      end
      step(10);
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_single_hit();
      test_multiplicity();
      test_backpressure();
      test_holdoff();
      test_reset_mid_event();
      test_width32();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
